// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the processor run-control logic.
package proc_ctrl_pkg;

  localparam int unsigned CYCLE_W_DEFAULT = 16;

  // Instruction substituted in front of the decoder while the core is gated off.
  localparam logic [8:0] NOP_INSN = 9'b100000000;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun,
    StDone
  } run_state_t;

  function automatic logic [8:0] issue_insn(input logic run_en, input logic [8:0] insn);
    return run_en ? insn : NOP_INSN;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-value compare flag.
module sat_counter #(
  parameter int unsigned      WIDTH        = 16,
  parameter bit               HAS_TERMINAL = 1'b1,
  parameter logic [WIDTH-1:0] TERMINAL     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count       = count_q;
  assign at_terminal = HAS_TERMINAL && (count_q == TERMINAL);

endmodule

// File: rtl/run_controller.sv
// Run-sequencing FSM: start/ack handshake, core reset pulse, issue gating, cycle count.
// Optional run timeout is enabled by defining RUN_CTRL_TIMEOUT_EN.
module run_controller
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned CYCLE_W        = CYCLE_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               done_insn,
  output logic               run_en,
  output logic               core_rst,
  output logic               ack,
  output logic               timed_out,
  output logic [CYCLE_W-1:0] cycle_count
);

`ifdef RUN_CTRL_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  // Compare against T-1 so the run ends with the count landing exactly on T.
  localparam logic [CYCLE_W-1:0] Terminal = CYCLE_W'(TIMEOUT_CYCLES - 1);

  run_state_t state_q, state_d;
  logic       at_terminal;
  logic       timeout_hit;

  assign timeout_hit = TimeoutEn && at_terminal;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StArmed;
      StArmed: if (!start) state_d = StRun;
      StRun:   if (done_insn || timeout_hit) state_d = StDone;
      StDone:  if (start) state_d = StArmed;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      run_en    <= 1'b0;
      core_rst  <= 1'b0;
      ack       <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_en   <= (state_d == StRun);
      core_rst <= (state_d == StArmed);
      ack      <= (state_d == StDone);
      if (state_d == StArmed) begin
        timed_out <= 1'b0;
      end else if ((state_q == StRun) && !done_insn && timeout_hit) begin
        timed_out <= 1'b1;
      end
    end
  end

  // Clear on entry to ARMED so the count reads 0 for the whole reset pulse.
  sat_counter #(
    .WIDTH        (CYCLE_W),
    .HAS_TERMINAL (TimeoutEn),
    .TERMINAL     (Terminal)
  ) u_cycle_ctr (
    .clk         (clk),
    .reset       (reset),
    .clear       (state_d == StArmed),
    .enable      (state_q == StRun),
    .count       (cycle_count),
    .at_terminal (at_terminal)
  );

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: vector table plus multi-cycle corner sequences.
module tb_run_controller;

  localparam int unsigned CW = 4;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          done_insn;
  logic          run_en;
  logic          core_rst;
  logic          ack;
  logic          timed_out;
  logic [CW-1:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          start;
    logic          done_insn;
    logic          run_en;
    logic          core_rst;
    logic          ack;
    logic          timed_out;
    logic [CW-1:0] count;
  } vec_t;

  vec_t vecs[17];

  run_controller #(
    .CYCLE_W        (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done_insn   (done_insn),
    .run_en      (run_en),
    .core_rst    (core_rst),
    .ack         (ack),
    .timed_out   (timed_out),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input int r, input int c, input int a,
                            input int t, input int cnt);
    check({name, ".run_en"}, int'(run_en), r);
    check({name, ".core_rst"}, int'(core_rst), c);
    check({name, ".ack"}, int'(ack), a);
    check({name, ".timed_out"}, int'(timed_out), t);
    check({name, ".cycle_count"}, int'(cycle_count), cnt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT displaying RUN cycle 1 (count 0).
  task automatic arm();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  initial begin
    // start, done | run_en, core_rst, ack, timed_out, count (after the edge)
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};  // done in IDLE ignored
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5};  // done in RUN cycle 5
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};  // back-to-back restart
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};  // done in ARMED ignored
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};  // start ignored in RUN
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2};  // done in RUN cycle 2
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2};

    reset     = 1'b1;
    start     = 1'b0;
    done_insn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      start     = vecs[i].start;
      done_insn = vecs[i].done_insn;
      step();
      check_outs($sformatf("vec%0d", i), int'(vecs[i].run_en), int'(vecs[i].core_rst),
                 int'(vecs[i].ack), int'(vecs[i].timed_out), int'(vecs[i].count));
    end
    done_insn = 1'b0;

    // No done_insn: timeout after TO cycles, or free-run to saturation without it.
    arm();
    for (int i = 0; i < int'(TO); i++) begin
      check($sformatf("to_run%0d.run_en", i), int'(run_en), 1);
      check($sformatf("to_run%0d.count", i), int'(cycle_count), i);
      step();
    end
`ifdef RUN_CTRL_TIMEOUT_EN
    check_outs("timeout", 0, 0, 1, 1, int'(TO));
`else
    check_outs("no_timeout", 1, 0, 0, 0, int'(TO));
    repeat (7) step();
    check_outs("sat_reach", 1, 0, 0, 0, 15);
    step();
    check_outs("sat_hold", 1, 0, 0, 0, 15);
    done_insn = 1'b1;
    step();
    done_insn = 1'b0;
    check_outs("sat_done", 0, 0, 1, 0, 15);
`endif

    // done_insn in RUN cycle TO coincides with the timeout condition; done wins.
    arm();
    repeat (int'(TO) - 1) step();
    check("coll_pre.count", int'(cycle_count), int'(TO) - 1);
    done_insn = 1'b1;
    step();
    done_insn = 1'b0;
    check_outs("collision", 0, 0, 1, 0, int'(TO));

    // Asynchronous reset in RUN cycle 3, then a normal run.
    arm();
    step();
    step();
    check("pre_rst.count", int'(cycle_count), 2);
    #2;
    reset = 1'b1;
    #1;
    check_outs("mid_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    step();
    check_outs("post_rst_armed", 0, 1, 0, 0, 0);
    start = 1'b0;
    step();
    check_outs("post_rst_run", 1, 0, 0, 0, 0);
    done_insn = 1'b1;
    step();
    done_insn = 1'b0;
    check_outs("post_rst_done", 0, 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
